// File: rtl/counter_pkg.sv
// Shared widths and default parameter values for the 99-second countdown timer.
package counter_pkg;

  localparam int CNT_W            = 7;
  localparam int DEFAULT_START    = 99;
  localparam int DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/counter_99sec_dn_tick_gen.sv
// One-second prescaler: counts clkIn edges 0..TICK_DIV-1 and flags the last one.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clkIn,
  input  logic rst,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] PRE_LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] PRE_NEAR = W'(TICK_DIV - 2);
  localparam logic [W-1:0] PRE_ONE  = W'(1);

  logic [W-1:0] r_pre;
  logic         r_tick;

  // Tick is registered one step ahead so it is high exactly while r_pre == TICK_DIV-1.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_pre  <= {W{1'b0}};
      r_tick <= 1'b0;
    end else begin
      if (r_pre == PRE_LAST) begin
        r_pre <= {W{1'b0}};
      end else begin
        r_pre <= r_pre + PRE_ONE;
      end
      r_tick <= (r_pre == PRE_NEAR);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/counter_99sec_dn.sv
// Seconds countdown timer START_VAL..0 with expiry flag q2.
// Optional build macro COUNTER_AUTO_RELOAD_EN reloads START_VAL after expiry.
module counter_99sec_dn
  import counter_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int START_VAL = DEFAULT_START
) (
  input  logic             clkIn,
  input  logic             rst,
  output logic [CNT_W-1:0] q,
  output logic             q2
);

  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_VAL);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  logic             w_tick;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_q2_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_q2;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clkIn (clkIn),
    .rst   (rst),
    .tick  (w_tick)
  );

  // Next-state: decrement on tick, flag expiry on the 1 -> 0 step, then hold or reload.
  always_comb begin
    w_count_nxt = r_count;
    w_q2_nxt    = r_q2;
    if (w_tick) begin
      if (r_count != CNT_ZERO) begin
        w_count_nxt = r_count - CNT_ONE;
        w_q2_nxt    = (r_count == CNT_ONE);
      end else begin
`ifdef COUNTER_AUTO_RELOAD_EN
        w_count_nxt = CNT_START;
        w_q2_nxt    = 1'b0;
`else
        w_count_nxt = CNT_ZERO;
        w_q2_nxt    = 1'b1;
`endif
      end
    end else begin
      w_count_nxt = r_count;
      w_q2_nxt    = r_q2;
    end
  end

  // Count and expiry registers; reset restores the full count immediately.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_count <= CNT_START;
      r_q2    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_q2    <= w_q2_nxt;
    end
  end

  assign q  = r_count;
  assign q2 = r_q2;

endmodule

// File: tb/tb_counter_99sec_dn.sv
// Directed bench for counter_99sec_dn with TICK_DIV=4, START_VAL=99.
module tb_counter_99sec_dn;

  logic       clkIn;
  logic       rst;
  logic [6:0] q;
  logic       q2;

  int total;
  int bad;

  counter_99sec_dn #(
    .TICK_DIV  (4),
    .START_VAL (99)
  ) dut (
    .clkIn (clkIn),
    .rst   (rst),
    .q     (q),
    .q2    (q2)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clkIn);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    step(3);
    chk("reset_q", {1'b0, q}, 8'd99);
    chk("reset_q2", {7'd0, q2}, 8'd0);

    rst = 1'b0;
    for (int e = 1; e <= 396; e++) begin
      step(1);
      chk("run_q", {1'b0, q}, 8'(99 - e / 4));
      chk("run_q2", {7'd0, q2}, (e >= 396) ? 8'd1 : 8'd0);
    end

    for (int k = 1; k <= 40; k++) begin
      step(1);
`ifdef COUNTER_AUTO_RELOAD_EN
      chk("reload_q", {1'b0, q}, (k < 4) ? 8'd0 : 8'(99 - (k - 4) / 4));
      chk("reload_q2", {7'd0, q2}, (k < 4) ? 8'd1 : 8'd0);
`else
      chk("hold_q", {1'b0, q}, 8'd0);
      chk("hold_q2", {7'd0, q2}, 8'd1);
`endif
    end

    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", {1'b0, q}, 8'd99);
    chk("async_rst_q2", {7'd0, q2}, 8'd0);
    for (int c = 0; c < 50; c++) begin
      step(1);
      chk("rst_hold_q", {1'b0, q}, 8'd99);
      chk("rst_hold_q2", {7'd0, q2}, 8'd0);
    end

    rst = 1'b0;
    step(168);
    chk("mid_q57", {1'b0, q}, 8'd57);
    chk("mid_q2", {7'd0, q2}, 8'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_q", {1'b0, q}, 8'd99);
    chk("mid_rst_q2", {7'd0, q2}, 8'd0);
    step(5);
    chk("mid_rst_hold_q", {1'b0, q}, 8'd99);

    rst = 1'b0;
    step(3);
    chk("after_rst_3_q", {1'b0, q}, 8'd99);
    step(1);
    chk("after_rst_4_q", {1'b0, q}, 8'd98);
    step(4);
    chk("after_rst_8_q", {1'b0, q}, 8'd97);
    chk("after_rst_q2", {7'd0, q2}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
